// File: rtl/mem_arbiter.sv
// Two-port fetch/data arbiter in front of one single-port fixed-latency memory.
// Optional wait-cycle statistics ports are enabled with `define MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DReady,
  output logic        StallIF,
  output logic        StallMEM,
  output logic        MemEn,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] IWaitCnt,
  output logic [15:0] DWaitCnt
`endif
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;
  logic          iready_q, iready_d;
  logic          dready_q, dready_d;

  logic i_elig, d_elig;
  logic grant_i, grant_d, done;

  // A port whose Ready pulse is showing this cycle is not eligible again yet.
  assign i_elig = IReq & ~iready_q;
  assign d_elig = DReq & ~dready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = d_elig;
        grant_i = i_elig & ~d_elig;
      end
      BUSY_I: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          done     = 1'b1;
          irdata_d = MemRdata;
          iready_d = 1'b1;
          grant_d  = d_elig;
        end
      end
      BUSY_D: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          done     = 1'b1;
          dready_d = 1'b1;
          grant_i  = i_elig;
          if (!we_q) begin
            drdata_d = MemRdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Grants taken on a completion edge hand over with no idle bubble.
    if (grant_d) begin
      state_d = BUSY_D;
      cnt_d   = CNT_INIT;
      en_d    = 1'b1;
      we_d    = DWe;
      addr_d  = DAddr;
      wdata_d = DWdata;
    end else if (grant_i) begin
      state_d = BUSY_I;
      cnt_d   = CNT_INIT;
      en_d    = 1'b1;
      we_d    = 1'b0;
      addr_d  = IAddr;
    end else if (done) begin
      state_d = IDLE;
      en_d    = 1'b0;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
    end
  end

  assign IRdata   = irdata_q;
  assign DRdata   = drdata_q;
  assign IReady   = iready_q;
  assign DReady   = dready_q;
  assign MemEn    = en_q;
  assign MemWe    = we_q;
  assign MemAddr  = addr_q;
  assign MemWdata = wdata_q;
  assign StallIF  = IReq & ~iready_q;
  assign StallMEM = DReq & ~dready_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] iwait_q, iwait_d;
  logic [15:0] dwait_q, dwait_d;

  // Saturating stall-cycle counters.
  always_comb begin
    iwait_d = iwait_q;
    dwait_d = dwait_q;
    if (StallIF && (iwait_q != 16'hFFFF)) begin
      iwait_d = iwait_q + 16'd1;
    end
    if (StallMEM && (dwait_q != 16'hFFFF)) begin
      dwait_d = dwait_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iwait_q <= '0;
      dwait_q <= '0;
    end else begin
      iwait_q <= iwait_d;
      dwait_q <= dwait_d;
    end
  end

  assign IWaitCnt = iwait_q;
  assign DWaitCnt = dwait_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing scenarios plus random two-port traffic.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWdata;
  logic [31:0] IRdata, DRdata;
  logic        IReady, DReady, StallIF, StallMEM, MemEn, MemWe;
  logic [31:0] MemAddr, MemWdata;
  logic [31:0] MemRdata = 32'h0;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] IWaitCnt, DWaitCnt;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DReady(DReady),
    .StallIF(StallIF), .StallMEM(StallMEM),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata)
`ifdef MEM_ARB_STATS_EN
    , .IWaitCnt(IWaitCnt), .DWaitCnt(DWaitCnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] d_last = 32'h0;
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] iexp, dexp;
  logic i_prev = 1'b0, d_prev = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory model: writes on the edge, read data presented from the latched address.
  always @(posedge clk) if (MemEn && MemWe) mem[MemAddr] = MemWdata;
  always @(negedge clk) MemRdata = mem.exists(MemAddr) ? mem[MemAddr] : init_word(MemAddr);

  // Scoreboard: each Ready pulse pops the expected read data for that port.
  always @(negedge clk) begin
    if (IReady === 1'b1) begin
      checks++;
      if (i_prev) begin
        failures++; $display("FAIL ipulse: IReady=1 two cycles running, required single pulse");
      end else if (iq.size() == 0) begin
        failures++; $display("FAIL iready_unexpected: IReady=1 with nothing outstanding");
      end else begin
        iexp = iq.pop_front();
        if (IRdata !== iexp) begin
          failures++; $display("FAIL irdata: got %h required %h", IRdata, iexp);
        end
      end
    end
    if (DReady === 1'b1) begin
      checks++;
      if (d_prev) begin
        failures++; $display("FAIL dpulse: DReady=1 two cycles running, required single pulse");
      end else if (dq.size() == 0) begin
        failures++; $display("FAIL dready_unexpected: DReady=1 with nothing outstanding");
      end else begin
        dexp = dq.pop_front();
        if (DRdata !== dexp) begin
          failures++; $display("FAIL drdata: got %h required %h", DRdata, dexp);
        end
      end
    end
    i_prev = IReady;
    d_prev = DReady;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; IReq = 1'b1; DReq = 1'b0; DWe = 1'b0;
    IAddr = 32'h0; DAddr = 32'h0; DWdata = 32'h0;
    #2;
    checks++;
    if ({MemEn, MemWe, IReady, DReady} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: {en,we,ir,dr}=%b required 0000", {MemEn, MemWe, IReady, DReady});
    end
    checks++;
    if ({MemAddr, MemWdata, IRdata, DRdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data: addr=%h wdata=%h ird=%h drd=%h required all 0", MemAddr, MemWdata, IRdata, DRdata);
    end
    checks++;
    if ({StallIF, StallMEM} !== 2'b10) begin
      failures++; $display("FAIL reset_stall: {sif,smem}=%b required 10", {StallIF, StallMEM});
    end
    tick();
    checks++;
    if (MemEn !== 1'b0) begin
      failures++; $display("FAIL reset_hold: MemEn=%b required 0 while reset held", MemEn);
    end
    IReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lone_fetch;
    mem[32'h4] = 32'h2010_0005;
    ref_mem[32'h4] = 32'h2010_0005;
    IReq = 1'b1; IAddr = 32'h4;
    iq.push_back(32'h2010_0005);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (StallIF !== (c <= 2)) begin
        failures++; $display("FAIL fetch_stall c%0d: StallIF=%b required %b", c, StallIF, c <= 2);
      end
      checks++;
      if (MemEn !== (c == 1 || c == 2)) begin
        failures++; $display("FAIL fetch_en c%0d: MemEn=%b required %b", c, MemEn, c == 1 || c == 2);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (MemAddr !== 32'h4) begin
          failures++; $display("FAIL fetch_addr c%0d: MemAddr=%h required 00000004", c, MemAddr);
        end
      end
      checks++;
      if (IReady !== (c == 3)) begin
        failures++; $display("FAIL fetch_ready c%0d: IReady=%b required %b", c, IReady, c == 3);
      end
      tick();
      if (c == 3) IReq = 1'b0;
    end
  endtask

  task automatic test_contention;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] i0, d0;
    i0 = IWaitCnt; d0 = DWaitCnt;
`endif
    IReq = 1'b1; IAddr = 32'h8;
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h50;
    d_last = ref_read(32'h50);
    dq.push_back(d_last);
    iq.push_back(ref_read(32'h8));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (MemEn !== (c >= 1 && c <= 4) || MemWe !== 1'b0) begin
        failures++; $display("FAIL cont_en c%0d: MemEn=%b MemWe=%b required %b 0", c, MemEn, MemWe, c >= 1 && c <= 4);
      end
      checks++;
      if (DReady !== (c == 3) || IReady !== (c == 5)) begin
        failures++; $display("FAIL cont_ready c%0d: DReady=%b IReady=%b required %b %b", c, DReady, IReady, c == 3, c == 5);
      end
      checks++;
      if (StallMEM !== (c <= 2) || StallIF !== (c <= 4)) begin
        failures++; $display("FAIL cont_stall c%0d: StallMEM=%b StallIF=%b required %b %b", c, StallMEM, StallIF, c <= 2, c <= 4);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (MemAddr !== ((c <= 2) ? 32'h50 : 32'h8)) begin
          failures++; $display("FAIL cont_addr c%0d: MemAddr=%h required %h", c, MemAddr, (c <= 2) ? 32'h50 : 32'h8);
        end
      end
      tick();
      if (c == 3) DReq = 1'b0;
      if (c == 5) IReq = 1'b0;
    end
`ifdef MEM_ARB_STATS_EN
    checks++;
    if (16'(DWaitCnt - d0) !== 16'd3 || 16'(IWaitCnt - i0) !== 16'd5) begin
      failures++; $display("FAIL stats: dwait+%0d iwait+%0d required 3 5", 16'(DWaitCnt - d0), 16'(IWaitCnt - i0));
    end
`endif
  endtask

  task automatic test_store;
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h54; DWdata = 32'hDEAD_BEEF;
    ref_mem[32'h54] = 32'hDEAD_BEEF;
    dq.push_back(d_last);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (MemWe !== (c == 1 || c == 2) || MemEn !== (c == 1 || c == 2)) begin
        failures++; $display("FAIL store_we c%0d: MemWe=%b MemEn=%b required %b", c, MemWe, MemEn, c == 1 || c == 2);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (MemWdata !== 32'hDEAD_BEEF || MemAddr !== 32'h54) begin
          failures++; $display("FAIL store_bus c%0d: addr=%h wdata=%h required 00000054 deadbeef", c, MemAddr, MemWdata);
        end
      end
      checks++;
      if (DReady !== (c == 3)) begin
        failures++; $display("FAIL store_ready c%0d: DReady=%b required %b", c, DReady, c == 3);
      end
      tick();
      if (c == 3) begin DReq = 1'b0; DWe = 1'b0; end
    end
  endtask

  task automatic test_no_regrant;
    IReq = 1'b1; IAddr = 32'h10;
    iq.push_back(ref_read(32'h10));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (MemEn !== (c == 1 || c == 2)) begin
        failures++; $display("FAIL noregrant_en c%0d: MemEn=%b required %b", c, MemEn, c == 1 || c == 2);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (MemAddr !== 32'h10) begin
          failures++; $display("FAIL noregrant_addr c%0d: MemAddr=%h required 00000010", c, MemAddr);
        end
      end
      checks++;
      if (IReady !== (c == 3)) begin
        failures++; $display("FAIL noregrant_ready c%0d: IReady=%b required %b", c, IReady, c == 3);
      end
      tick();
      if (c == 0) IAddr = 32'h99;
      if (c == 3) IReq = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h60; DWdata = 32'h1234_5678;
    tick();
    tick();
    checks++;
    if (MemWe !== 1'b1) begin
      failures++; $display("FAIL rmid_pre: MemWe=%b required 1 in second busy cycle", MemWe);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({MemEn, MemWe, IReady, DReady} !== 4'b0000) begin
      failures++; $display("FAIL rmid_ctrl: {en,we,ir,dr}=%b required 0000", {MemEn, MemWe, IReady, DReady});
    end
    checks++;
    if ({MemAddr, MemWdata, IRdata, DRdata} !== 128'h0) begin
      failures++; $display("FAIL rmid_data: addr=%h wdata=%h ird=%h drd=%h required all 0", MemAddr, MemWdata, IRdata, DRdata);
    end
    DReq = 1'b0; DWe = 1'b0;
    d_last = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (MemEn !== 1'b0) begin
      failures++; $display("FAIL rmid_after: MemEn=%b required 0 after abandoned access", MemEn);
    end
  endtask

  task automatic test_back_to_back;
    fork
      begin : ithread
        for (int k = 0; k < 10; k++) begin
          automatic logic [31:0] a = 32'h1000 + 32'(4 * $urandom_range(0, 63));
          automatic int n = 0;
          automatic int gap = $urandom_range(0, 2);
          IAddr = a; IReq = 1'b1;
          iq.push_back(ref_read(a));
          do begin @(negedge clk); n++; end while (IReady !== 1'b1 && n < 50);
          checks++;
          if (n >= 50) begin
            failures++; $display("FAIL b2b_i_timeout: IReady=%b after %0d cycles, required 1", IReady, n);
          end
          tick();
          if (gap > 0) begin IReq = 1'b0; repeat (gap) tick(); end
        end
        IReq = 1'b0;
      end
      begin : dthread
        for (int k = 0; k < 10; k++) begin
          automatic logic [31:0] a = 32'h2000 + 32'(4 * $urandom_range(0, 15));
          automatic logic st = 1'($urandom_range(0, 1));
          automatic logic [31:0] wd = $urandom;
          automatic int n = 0;
          automatic int gap = $urandom_range(0, 2);
          DAddr = a; DWe = st; DWdata = wd; DReq = 1'b1;
          if (st) begin
            ref_mem[a] = wd;
          end else begin
            d_last = ref_read(a);
          end
          dq.push_back(d_last);
          do begin @(negedge clk); n++; end while (DReady !== 1'b1 && n < 50);
          checks++;
          if (n >= 50) begin
            failures++; $display("FAIL b2b_d_timeout: DReady=%b after %0d cycles, required 1", DReady, n);
          end
          tick();
          if (gap > 0) begin DReq = 1'b0; DWe = 1'b0; repeat (gap) tick(); end
        end
        DReq = 1'b0; DWe = 1'b0;
      end
    join
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_store();
    test_no_regrant();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      failures++; $display("FAIL drain: %0d fetch and %0d data results outstanding, required 0 0", iq.size(), dq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
